muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer_pkg.sv | 23 ++
 rtl/muldiv_sequencer_if.sv | 26 ++
 rtl/muldiv_sequencer.sv | 163 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the MULTU/DIVU sequencer: ALU function codes, op encodings, FSM states.
package muldiv_sequencer_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  localparam logic [4:0] ITER_LAST = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_CMP,
    ST_DIV_SUB,
    ST_DONE
  } state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result handshake plus the shared-ALU operand bus between the sequencer and its parent.
interface muldiv_sequencer_if;
  logic        start;
  logic        op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;
  logic [2:0]  alu_control;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;

  modport master (
    output start, op, operand_a, operand_b, alu_result,
    input  busy, done, hi, lo, div_by_zero, alu_control, alu_a, alu_b
  );

  modport slave (
    input  start, op, operand_a, operand_b, alu_result,
    output busy, done, hi, lo, div_by_zero, alu_control, alu_a, alu_b
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MULTU (shift-add) / DIVU (restoring) sequencer driving an external 32-bit ALU.
// Divide support is built only when MULDIV_DIV_EN is defined.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  muldiv_sequencer_if.slave bus
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mcand_q, mcand_d;

  logic        busy, done, carry;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b;

`ifdef MULDIV_DIV_EN
  logic [31:0] divisor_q, divisor_d;
  logic        lt_q, lt_d;
  logic        dbz_q, dbz_d;
  logic [31:0] rs;
  logic        ovf;

  assign rs  = {hi_q[30:0], lo_q[31]};
  assign ovf = hi_q[31];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
`ifdef MULDIV_DIV_EN
      divisor_q <= '0;
      lt_q      <= 1'b0;
      dbz_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
`ifdef MULDIV_DIV_EN
      divisor_q <= divisor_d;
      lt_q      <= lt_d;
      dbz_q     <= dbz_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    busy      = 1'b0;
    done      = 1'b0;
    carry     = 1'b0;
    alu_ctrl  = ALU_AND;
    alu_a     = '0;
    alu_b     = '0;
`ifdef MULDIV_DIV_EN
    divisor_d = divisor_q;
    lt_d      = lt_q;
    dbz_d     = dbz_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_d = bus.operand_a;
          hi_d    = '0;
          cnt_d   = '0;
          if (bus.op == OP_MULTU) begin
            lo_d    = bus.operand_b;
            state_d = ST_MUL;
          end else begin
`ifdef MULDIV_DIV_EN
            divisor_d = bus.operand_b;
            dbz_d     = 1'b0;
            if (bus.operand_b == '0) begin
              hi_d    = bus.operand_a;
              lo_d    = '1;
              dbz_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              lo_d    = bus.operand_a;
              state_d = ST_DIV_CMP;
            end
`else
            lo_d    = '0;
            state_d = ST_DONE;
`endif
          end
        end
      end

      ST_MUL: begin
        busy     = 1'b1;
        alu_ctrl = ALU_ADD;
        alu_a    = hi_q;
        alu_b    = lo_q[0] ? mcand_q : '0;
        // Wrapped sum below the addend means the 33rd product bit was carried out.
        carry    = bus.alu_result < hi_q;
        hi_d     = {carry, bus.alu_result[31:1]};
        lo_d     = {bus.alu_result[0], lo_q[31:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == ITER_LAST) state_d = ST_DONE;
      end

`ifdef MULDIV_DIV_EN
      ST_DIV_CMP: begin
        busy     = 1'b1;
        alu_ctrl = ALU_SLT;
        alu_a    = rs;
        alu_b    = divisor_q;
        lt_d     = bus.alu_result[0] & ~ovf;
        state_d  = ST_DIV_SUB;
      end

      ST_DIV_SUB: begin
        busy     = 1'b1;
        alu_ctrl = ALU_SUB;
        alu_a    = rs;
        alu_b    = divisor_q;
        hi_d     = lt_q ? rs : bus.alu_result;
        lo_d     = {lo_q[30:0], ~lt_q};
        cnt_d    = cnt_q + 5'd1;
        state_d  = (cnt_q == ITER_LAST) ? ST_DONE : ST_DIV_CMP;
      end
`endif

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.alu_control = alu_ctrl;
  assign bus.alu_a       = alu_a;
  assign bus.alu_b       = alu_b;
`ifdef MULDIV_DIV_EN
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer with a behavioural ALU standing in for the parent's.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus();

  muldiv_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Compare function answers an unsigned less-than so full-range divisors divide correctly.
  always_comb begin
    case (bus.alu_control)
      ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      ALU_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
      ALU_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
      ALU_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
      ALU_SLT: bus.alu_result = {31'd0, bus.alu_a < bus.alu_b};
      default: bus.alu_result = '0;
    endcase
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  // Issues one request and waits for done; leaves the caller at the negedge inside the DONE cycle.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at,
                        output int lat, output int busy_cycles, output int bad_bus);
    @(negedge clk);
    bad_bus = 0;
    if (bus.alu_control !== 3'b000 || bus.alu_a !== '0 || bus.alu_b !== '0) bad_bus++;
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(negedge clk);
    bus.start   = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) busy_cycles++;
      if (op == OP_MULTU) begin
        if (bus.alu_control !== ALU_ADD) bad_bus++;
      end else if (bus.alu_control !== (((lat % 2) == 0) ? ALU_SLT : ALU_SUB)) begin
        bad_bus++;
      end
      if (lat == pulse_at) begin
        bus.start     = 1'b1;
        bus.op        = ~op;
        bus.operand_a = 32'hDEAD_BEEF;
        bus.operand_b = 32'h0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    if (bus.busy !== 1'b0) bad_bus++;
    if (bus.alu_control !== 3'b000 || bus.alu_a !== '0 || bus.alu_b !== '0) bad_bus++;
  endtask

  int lat, bcy, bad, n;

  initial begin
    bus.start     = 1'b0;
    bus.op        = OP_MULTU;
    bus.operand_a = '0;
    bus.operand_b = '0;

    vecs[0] = '{OP_MULTU, 32'd7,         32'd6,         32'd0,         32'd42,        1'b0, 32};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32};
    vecs[2] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 32};
`ifdef MULDIV_DIV_EN
    vecs[3] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 64};
    vecs[4] = '{OP_DIVU,  32'h8000_0000, 32'd3,         32'd2,         32'h2AAA_AAAA, 1'b0, 64};
    vecs[5] = '{OP_DIVU,  32'd5,         32'hFFFF_FFFF, 32'd5,         32'd0,         1'b0, 64};
    vecs[6] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1,         1'b0, 64};
    vecs[7] = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 0};
`else
    vecs[3] = '{OP_DIVU,  32'd100,       32'd7,         32'd0,         32'd0,         1'b0, 0};
    vecs[4] = '{OP_DIVU,  32'h8000_0000, 32'd3,         32'd0,         32'd0,         1'b0, 0};
    vecs[5] = '{OP_DIVU,  32'd5,         32'hFFFF_FFFF, 32'd0,         32'd0,         1'b0, 0};
    vecs[6] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h8000_0001, 32'd0,         32'd0,         1'b0, 0};
    vecs[7] = '{OP_DIVU,  32'd5,         32'd0,         32'd0,         32'd0,         1'b0, 0};
`endif
    vecs[8] = '{OP_MULTU, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, 32};

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    check("rst_alu", {29'd0, bus.alu_control} | bus.alu_a | bus.alu_b, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, lat, bcy, bad);
      check($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
      check($sformatf("v%0d_dbz", i), {31'd0, bus.div_by_zero}, {31'd0, vecs[i].dbz});
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_busy_cycles", i), 32'(bcy), 32'(vecs[i].lat));
      check($sformatf("v%0d_alu_bus", i), 32'(bad), 32'd0);
    end

    run_op(OP_MULTU, 32'd7, 32'd6, 5, lat, bcy, bad);
    check("ignore_start_hi", bus.hi, 32'd0);
    check("ignore_start_lo", bus.lo, 32'd42);
    check("ignore_start_latency", 32'(lat), 32'd32);

    // Start held from the DONE cycle: refused at the edge ending DONE, accepted one edge later.
    bus.start     = 1'b1;
    bus.op        = OP_MULTU;
    bus.operand_a = 32'd2;
    bus.operand_b = 32'd2;
    @(negedge clk);
    check("b2b_first_edge_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check("b2b_second_edge_busy", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_latency", 32'(n), 32'd32);
    check("b2b_lo", bus.lo, 32'd4);

    @(negedge clk);
    bus.start     = 1'b1;
    bus.op        = OP_MULTU;
    bus.operand_a = 32'h1234_5678;
    bus.operand_b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_MULTU, 32'd3, 32'd3, -1, lat, bcy, bad);
    check("after_rst_hi", bus.hi, 32'd0);
    check("after_rst_lo", bus.lo, 32'd9);
    check("after_rst_latency", 32'(lat), 32'd32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
